// File: rtl/uart_tx_stream_if.sv
// AXI-stream style byte handshake between a producer and the UART transmitter.
interface uart_tx_stream_if #(
   parameter int unsigned DATA_WIDTH = 8
);
   logic [DATA_WIDTH-1:0] tdata;
   logic                  tvalid;
   logic                  tready;

   modport master (output tdata, output tvalid, input tready);
   modport slave  (input tdata, input tvalid, output tready);
endinterface

// File: rtl/uart_tx_stream.sv
// UART transmitter: serialises stream words onto uart_txd, bit period = max(prescale,1)*8 clocks.
// Optional parity bit enabled by defining UART_TX_STREAM_PARITY_EN (adds input parity_odd).
module uart_tx_stream #(
   parameter int unsigned DATA_WIDTH = 8,
   parameter int unsigned STOP_BITS  = 1
) (
   input  logic                   clk,
   input  logic                   rst,
   uart_tx_stream_if.slave        s_axis,
   input  logic [15:0]            prescale,
`ifdef UART_TX_STREAM_PARITY_EN
   input  logic                   parity_odd,
`endif
   output logic                   uart_txd,
   output logic                   busy
);

`ifdef UART_TX_STREAM_PARITY_EN
   typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_e;
`else
   typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_e;
`endif

   state_e                  state_q, state_d;
   logic [18:0]             cnt_q, cnt_d;
   logic [18:0]             period_q, period_d;
   logic [3:0]              bit_q, bit_d;
   logic [DATA_WIDTH-1:0]   shreg_q, shreg_d;
   logic                    txd_q, txd_d;
   logic                    tready_q, tready_d;
   logic                    busy_q, busy_d;
`ifdef UART_TX_STREAM_PARITY_EN
   logic                    parity_q, parity_d;
`endif

   logic [15:0]             pre_eff;
   logic                    transfer;

   assign pre_eff  = (prescale == 16'd0) ? 16'd1 : prescale;
   assign transfer = s_axis.tvalid & tready_q;

   assign s_axis.tready = tready_q;
   assign uart_txd      = txd_q;
   assign busy          = busy_q;

   // cnt_q holds clocks remaining in the current bit; period_q is P-1 so the
   // reload value needs no subtraction on the critical bit-boundary path.
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      period_d = period_q;
      bit_d    = bit_q;
      shreg_d  = shreg_q;
      txd_d    = txd_q;
      tready_d = tready_q;
      busy_d   = busy_q;
`ifdef UART_TX_STREAM_PARITY_EN
      parity_d = parity_q;
`endif
      case (state_q)
         IDLE: begin
            txd_d    = 1'b1;
            tready_d = 1'b1;
            busy_d   = 1'b0;
            if (transfer) begin
               shreg_d  = s_axis.tdata;
               period_d = {pre_eff, 3'b000} - 19'd1;
               cnt_d    = {pre_eff, 3'b000} - 19'd1;
               state_d  = START;
               txd_d    = 1'b0;
               tready_d = 1'b0;
               busy_d   = 1'b1;
`ifdef UART_TX_STREAM_PARITY_EN
               parity_d = (^s_axis.tdata) ^ parity_odd;
`endif
            end
         end
         START: begin
            if (cnt_q == '0) begin
               state_d = DATA;
               cnt_d   = period_q;
               txd_d   = shreg_q[0];
               bit_d   = 4'(DATA_WIDTH - 1);
            end else begin
               cnt_d = cnt_q - 19'd1;
            end
         end
         DATA: begin
            if (cnt_q == '0) begin
               cnt_d = period_q;
               if (bit_q == '0) begin
`ifdef UART_TX_STREAM_PARITY_EN
                  state_d = PARITY;
                  txd_d   = parity_q;
`else
                  state_d = STOP;
                  txd_d   = 1'b1;
                  bit_d   = 4'(STOP_BITS - 1);
`endif
               end else begin
                  shreg_d = shreg_q >> 1;
                  txd_d   = shreg_q[1];
                  bit_d   = bit_q - 4'd1;
               end
            end else begin
               cnt_d = cnt_q - 19'd1;
            end
         end
`ifdef UART_TX_STREAM_PARITY_EN
         PARITY: begin
            if (cnt_q == '0) begin
               state_d = STOP;
               cnt_d   = period_q;
               txd_d   = 1'b1;
               bit_d   = 4'(STOP_BITS - 1);
            end else begin
               cnt_d = cnt_q - 19'd1;
            end
         end
`endif
         // Stop bits are counted in whole periods so the 19-bit counter never overflows.
         STOP: begin
            if (cnt_q == '0) begin
               if (bit_q == '0) begin
                  state_d  = IDLE;
                  tready_d = 1'b1;
                  busy_d   = 1'b0;
                  txd_d    = 1'b1;
               end else begin
                  bit_d = bit_q - 4'd1;
                  cnt_d = period_q;
               end
            end else begin
               cnt_d = cnt_q - 19'd1;
            end
         end
         default: begin
            state_d  = IDLE;
            txd_d    = 1'b1;
            tready_d = 1'b0;
            busy_d   = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         period_q <= '0;
         bit_q    <= '0;
         shreg_q  <= '0;
         txd_q    <= 1'b1;
         tready_q <= 1'b0;
         busy_q   <= 1'b0;
`ifdef UART_TX_STREAM_PARITY_EN
         parity_q <= 1'b0;
`endif
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         period_q <= period_d;
         bit_q    <= bit_d;
         shreg_q  <= shreg_d;
         txd_q    <= txd_d;
         tready_q <= tready_d;
         busy_q   <= busy_d;
`ifdef UART_TX_STREAM_PARITY_EN
         parity_q <= parity_d;
`endif
      end
   end

endmodule
